// File: rtl/segmented_memory_ctrl_pkg.sv
// Shared types and address decode helper for the segmented memory controller.
package segmem_pkg;

  localparam int unsigned SEL_W = 64;

  typedef enum logic [1:0] {
    FC_OK      = 2'd0,
    FC_RANGE   = 2'd1,
    FC_WPROT   = 2'd2,
    FC_ILLEGAL = 2'd3
  } fault_code_e;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic             is_data;
    logic [SEL_W-1:0] offset;
  } seg_sel_t;

  // Split a word address into segment select and offset within that segment.
  function automatic seg_sel_t seg_select(input logic [SEL_W-1:0] addr,
                                          input logic [SEL_W-1:0] instr_depth);
    seg_sel_t s;
    s.is_data = (addr >= instr_depth);
    s.offset  = s.is_data ? (addr - instr_depth) : addr;
    return s;
  endfunction

endpackage

// File: rtl/segmented_memory_ctrl_if.sv
// Request/response bus between the memory pipeline stage and the controller.
interface segmented_memory_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  import segmem_pkg::*;

  logic              req;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W/8-1:0] write_strb;
  logic              load_en;
  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] data_out;
  logic              fault;
  fault_code_e       fault_code;
  logic              clear_busy;

  modport master (
    output req, read, write, address, data_in, write_strb, load_en,
    input  ready, valid, data_out, fault, fault_code, clear_busy
  );

  modport slave (
    input  req, read, write, address, data_in, write_strb, load_en,
    output ready, valid, data_out, fault, fault_code, clear_busy
  );
endinterface

// File: rtl/segmented_memory_ctrl_bank.sv
// Single-port synchronous word array with byte-strobe write; no reset.
module segmem_bank #(
  parameter  int unsigned DEPTH  = 512,
  parameter  int unsigned DATA_W = 64,
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(DATA_W / 8); b++) begin
        if (strb[b]) r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= r_mem[idx];
  end
endmodule

// File: rtl/segmented_memory_ctrl.sv
// Two-segment word memory controller: decode, write protection, fault reporting
// and post-reset data-segment clear. Addresses up to 64 bits wide.
module segmented_memory_ctrl #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned INSTR_DEPTH = 512,
  parameter int unsigned DATA_DEPTH  = 512
) (
  input logic                    clk,
  input logic                    rst,
  segmented_memory_ctrl_if.slave bus
);
  import segmem_pkg::*;

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IIDX_W = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;
  localparam int unsigned DIDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  state_e            r_state, w_state_nxt;
  fault_code_e       w_code, r_fault_code, w_fault_code_nxt;
  seg_sel_t          w_sel;
  logic              w_accept, w_ok, w_we_i, w_we_d;
  logic [IIDX_W-1:0] w_iidx;
  logic [DIDX_W-1:0] w_didx, r_clr_idx;
  logic [STRB_W-1:0] w_d_strb;
  logic [DATA_W-1:0] w_d_wdata, w_i_rdata, w_d_rdata, r_data_out;
  logic              r_rd_ok, r_rd_data;
  logic              r_ready, r_valid, r_fault, r_clear_busy;
  logic              w_ready_nxt, w_valid_nxt, w_fault_nxt, w_clear_busy_nxt;

  // Request decode; the data-segment offset check is the full-width range check.
  always_comb begin
    w_sel  = seg_select(SEL_W'(bus.address), SEL_W'(INSTR_DEPTH));
    w_code = FC_OK;
    if (bus.read == bus.write) begin
      w_code = FC_ILLEGAL;
    end else if (w_sel.is_data && (w_sel.offset >= SEL_W'(DATA_DEPTH))) begin
      w_code = FC_RANGE;
    end else if (bus.write && !w_sel.is_data && !bus.load_en) begin
      w_code = FC_WPROT;
    end
  end

  assign w_accept = (r_state == S_IDLE) && bus.req;
  assign w_ok     = w_accept && (w_code == FC_OK);

  // Bank port steering; the clear sequence owns the data bank while in S_CLEAR.
  always_comb begin
    w_iidx    = IIDX_W'(w_sel.offset);
    w_we_i    = w_ok && bus.write && !w_sel.is_data;
    w_we_d    = w_ok && bus.write && w_sel.is_data;
    w_didx    = DIDX_W'(w_sel.offset);
    w_d_strb  = bus.write_strb;
    w_d_wdata = bus.data_in;
    if (r_state == S_CLEAR) begin
      w_we_d    = 1'b1;
      w_didx    = r_clr_idx;
      w_d_strb  = '1;
      w_d_wdata = '0;
    end
  end

  segmem_bank #(.DEPTH(INSTR_DEPTH), .DATA_W(DATA_W)) u_instr (
    .clk   (clk),
    .we    (w_we_i),
    .strb  (bus.write_strb),
    .idx   (w_iidx),
    .wdata (bus.data_in),
    .rdata (w_i_rdata)
  );

  segmem_bank #(.DEPTH(DATA_DEPTH), .DATA_W(DATA_W)) u_data (
    .clk   (clk),
    .we    (w_we_d),
    .strb  (w_d_strb),
    .idx   (w_didx),
    .wdata (w_d_wdata),
    .rdata (w_d_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_idx == DIDX_W'(DATA_DEPTH - 1)) w_state_nxt = S_IDLE;
      S_IDLE:  if (bus.req) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    w_ready_nxt      = (w_state_nxt == S_IDLE);
    w_valid_nxt      = (w_state_nxt == S_RESP);
    w_clear_busy_nxt = (w_state_nxt == S_CLEAR);
    w_fault_code_nxt = w_valid_nxt ? w_code : FC_OK;
    w_fault_nxt      = (w_fault_code_nxt != FC_OK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready      <= 1'b0;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FC_OK;
      r_clear_busy <= 1'b1;
      r_clr_idx    <= '0;
      r_rd_ok      <= 1'b0;
      r_rd_data    <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_ready      <= w_ready_nxt;
      r_valid      <= w_valid_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
      r_clear_busy <= w_clear_busy_nxt;
      r_clr_idx    <= (r_state == S_CLEAR) ? r_clr_idx + DIDX_W'(1) : '0;
      r_rd_ok      <= w_ok && bus.read;
      r_rd_data    <= w_sel.is_data;
      if ((r_state == S_RESP) && r_rd_ok) r_data_out <= r_rd_data ? w_d_rdata : w_i_rdata;
    end
  end

  // Read data comes straight from the bank register during the response, then holds.
  assign bus.data_out   = ((r_state == S_RESP) && r_rd_ok) ?
                          (r_rd_data ? w_d_rdata : w_i_rdata) : r_data_out;
  assign bus.ready      = r_ready;
  assign bus.valid      = r_valid;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.clear_busy = r_clear_busy;

endmodule

// File: tb/tb_segmented_memory_ctrl.sv
// Self-checking bench: directed vector table, reset corner cases, random traffic vs. array model.
module tb_segmented_memory_ctrl;
  import segmem_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned ID = 512;
  localparam int unsigned DD = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;

  segmented_memory_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  segmented_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .INSTR_DEPTH(ID), .DATA_DEPTH(DD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_instr [ID];
  logic [63:0] m_data  [DD];
  logic [63:0] m_dout;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        ld;
    logic [1:0]  code;
    logic        chk_d;
    logic [63:0] dexp;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] strb);
    logic [63:0] r = old_w;
    for (int b = 0; b < 8; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Behavioural model: plain arrays indexed by word address.
  task automatic model_access(input logic rd, input logic wr, input logic [63:0] addr,
                              input logic [63:0] data, input logic [7:0] strb, input logic ld,
                              output logic [1:0] code);
    if (rd == wr) code = 2'd3;
    else if (addr >= 64'(ID + DD)) code = 2'd1;
    else if (wr && addr < 64'(ID) && !ld) code = 2'd2;
    else begin
      code = 2'd0;
      if (addr < 64'(ID)) begin
        if (wr) m_instr[int'(addr)] = merge(m_instr[int'(addr)], data, strb);
        else    m_dout = m_instr[int'(addr)];
      end else begin
        if (wr) m_data[int'(addr) - int'(ID)] = merge(m_data[int'(addr) - int'(ID)], data, strb);
        else    m_dout = m_data[int'(addr) - int'(ID)];
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 64'(bus.ready), 64'd1);
  endtask

  task automatic count_clear(output int cycles, output int busy_bad, output int valid_seen);
    cycles = 0; busy_bad = 0; valid_seen = 0;
    while (!bus.ready && cycles < 2000) begin
      if (!bus.clear_busy) busy_bad++;
      if (bus.valid) valid_seen++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_txn(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [63:0] data, input logic [7:0] strb, input logic ld,
                         output logic [63:0] dout, output logic [1:0] code);
    logic [1:0] ecode;
    wait_ready();
    bus.req = 1'b1; bus.read = rd; bus.write = wr; bus.address = addr;
    bus.data_in = data; bus.write_strb = strb; bus.load_en = ld;
    @(posedge clk); #1;
    bus.req = 1'b0;
    model_access(rd, wr, addr, data, strb, ld, ecode);
    chk("valid_latency", 64'(bus.valid), 64'd1);
    dout = bus.data_out;
    code = bus.fault_code;
    chk("fault_code", 64'(bus.fault_code), 64'(ecode));
    chk("fault_flag", 64'(bus.fault), 64'(ecode != 2'd0));
    chk("data_out", bus.data_out, m_dout);
    @(posedge clk); #1;
    chk("valid_one_cycle", 64'(bus.valid), 64'd0);
  endtask

  initial begin
    int cyc, bb, vs;
    logic [63:0] d;
    logic [1:0]  c;

    tbl[0]  = '{1'b1, 1'b0, 64'd512,  64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'h0};
    tbl[1]  = '{1'b0, 1'b1, 64'd512,  64'h123456789ABCDEF0,    8'hFF, 1'b0, 2'd0, 1'b0, 64'h0};
    tbl[2]  = '{1'b1, 1'b0, 64'd512,  64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'h123456789ABCDEF0};
    tbl[3]  = '{1'b0, 1'b1, 64'd520,  64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 2'd0, 1'b0, 64'h0};
    tbl[4]  = '{1'b1, 1'b0, 64'd520,  64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'h0000_0000_FFFF_FFFF};
    tbl[5]  = '{1'b0, 1'b1, 64'd10,   64'h5555,                8'hFF, 1'b1, 2'd0, 1'b0, 64'h0};
    tbl[6]  = '{1'b0, 1'b1, 64'd10,   64'h1111,                8'hFF, 1'b0, 2'd2, 1'b0, 64'h0};
    tbl[7]  = '{1'b1, 1'b0, 64'd10,   64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'h5555};
    tbl[8]  = '{1'b0, 1'b1, 64'd10,   64'hDEAD,                8'hFF, 1'b1, 2'd0, 1'b0, 64'h0};
    tbl[9]  = '{1'b1, 1'b0, 64'd10,   64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'hDEAD};
    tbl[10] = '{1'b1, 1'b0, 64'd1024, 64'h0,                   8'h00, 1'b0, 2'd1, 1'b0, 64'h0};
    tbl[11] = '{1'b1, 1'b0, 64'd1023, 64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'h0};
    tbl[12] = '{1'b1, 1'b0, 64'h1_0000_0200, 64'h0,            8'h00, 1'b0, 2'd1, 1'b0, 64'h0};
    tbl[13] = '{1'b1, 1'b1, 64'd512,  64'h0,                   8'hFF, 1'b0, 2'd3, 1'b0, 64'h0};
    tbl[14] = '{1'b0, 1'b0, 64'd512,  64'h0,                   8'hFF, 1'b0, 2'd3, 1'b0, 64'h0};
    tbl[15] = '{1'b0, 1'b1, 64'd511,  64'hCAFE,                8'hFF, 1'b1, 2'd0, 1'b0, 64'h0};
    tbl[16] = '{1'b0, 1'b1, 64'd511,  64'hFFFF,                8'h00, 1'b1, 2'd0, 1'b0, 64'h0};
    tbl[17] = '{1'b1, 1'b0, 64'd511,  64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'hCAFE};
    tbl[18] = '{1'b0, 1'b1, 64'd512,  64'h0,                   8'h00, 1'b0, 2'd0, 1'b0, 64'h0};
    tbl[19] = '{1'b1, 1'b0, 64'd512,  64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'h123456789ABCDEF0};
    tbl[20] = '{1'b0, 1'b1, 64'd600,  64'hA5A5A5A5_A5A5A5A5,   8'hF0, 1'b0, 2'd0, 1'b0, 64'h0};
    tbl[21] = '{1'b1, 1'b0, 64'd600,  64'h0,                   8'h00, 1'b0, 2'd0, 1'b1, 64'hA5A5A5A5_00000000};

    bus.req = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
    bus.data_in = '0; bus.write_strb = '0; bus.load_en = 1'b0;

    // Reset values and full-length clear.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_data_out", bus.data_out, 64'd0);
    chk("rst_fault", 64'(bus.fault), 64'd0);
    chk("rst_fault_code", 64'(bus.fault_code), 64'd0);
    chk("rst_clear_busy", 64'(bus.clear_busy), 64'd1);
    rst = 1'b0;
    bus.req = 1'b1; bus.read = 1'b1; bus.address = 64'd512;  // ignored during clear
    count_clear(cyc, bb, vs);
    bus.req = 1'b0;
    chk("clear_cycles", 64'(cyc), 64'd512);
    chk("clear_busy_held", 64'(bb), 64'd0);
    chk("no_valid_in_clear", 64'(vs), 64'd0);
    chk("clear_busy_done", 64'(bus.clear_busy), 64'd0);
    for (int i = 0; i < int'(DD); i++) m_data[i] = 64'h0;
    m_dout = 64'h0;

    // Directed vectors.
    for (int i = 0; i < 22; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].ld, d, c);
      chk($sformatf("tbl%0d_code", i), 64'(c), 64'(tbl[i].code));
      if (tbl[i].chk_d) chk($sformatf("tbl%0d_data", i), d, tbl[i].dexp);
    end

    // Reset during a response, then again mid-clear: clear restarts, instr survives.
    wait_ready();
    bus.req = 1'b1; bus.read = 1'b0; bus.write = 1'b1; bus.address = 64'd512;
    bus.data_in = 64'hAAAA_BBBB; bus.write_strb = 8'hFF; bus.load_en = 1'b0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("resp_dropped_valid", 64'(bus.valid), 64'd0);
    chk("resp_rst_clear_busy", 64'(bus.clear_busy), 64'd1);
    chk("resp_rst_data_out", bus.data_out, 64'd0);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_clear(cyc, bb, vs);
    chk("reclear_cycles", 64'(cyc), 64'd512);
    chk("reclear_no_valid", 64'(vs), 64'd0);
    for (int i = 0; i < int'(DD); i++) m_data[i] = 64'h0;
    m_dout = 64'h0;
    run_txn(1'b1, 1'b0, 64'd512, 64'h0, 8'h00, 1'b0, d, c);
    chk("post_rst_read512", d, 64'h0);
    run_txn(1'b1, 1'b0, 64'd10, 64'h0, 8'h00, 1'b0, d, c);
    chk("post_rst_read10", d, 64'hDEAD);

    // Boot-load every instruction word so the model is fully defined.
    for (int a = 0; a < int'(ID); a++)
      run_txn(1'b0, 1'b1, 64'(a), {$urandom(), $urandom()}, 8'hFF, 1'b1, d, c);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      int unsigned op;
      logic rd, wr;
      logic [63:0] addr;
      op = $urandom_range(0, 9);
      rd = (op == 0) || (op >= 2 && op <= 5);
      wr = (op == 0) || (op >= 6);
      if ($urandom_range(0, 15) == 0) addr = {$urandom(), $urandom()};
      else addr = 64'($urandom_range(0, 1099));
      run_txn(rd, wr, addr, {$urandom(), $urandom()}, 8'($urandom()), 1'($urandom()), d, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
